// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               requesters, with a one-entry registered response slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    input  logic             rsp_ready
);

    localparam logic [3:0] c_ctrl_illegal = 4'b1111;
    localparam logic [0:0] c_slot_empty   = 1'b0;
    localparam logic [0:0] c_slot_full    = 1'b1;

    logic [0:0]       r_slot_state;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_err;
    logic             r_last_grant;

    logic w_slot_free;
    logic w_grant0;
    logic w_grant1;
    logic w_grant_any;
    logic w_illegal;

    assign w_slot_free = (r_slot_state == c_slot_empty) || rsp_ready;

    // On contention the requester that did not win last time takes the ALU.
    assign w_grant0 = !rst && w_slot_free && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = !rst && w_slot_free && req1_valid && (!req0_valid || !r_last_grant);
    assign w_grant_any = w_grant0 || w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_comb begin
        alu_ctrl = c_ctrl_illegal;
        alu_a    = '0;
        alu_b    = '0;
        if (w_grant0) begin
            alu_ctrl = req0_ctrl;
            alu_a    = req0_a;
            alu_b    = req0_b;
        end else if (w_grant1) begin
            alu_ctrl = req1_ctrl;
            alu_a    = req1_a;
            alu_b    = req1_b;
        end
    end

    assign w_illegal = (alu_ctrl == c_ctrl_illegal);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_state <= c_slot_empty;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            // A grant always refills the slot, covering the drain-and-reload case.
            r_slot_state <= c_slot_full;
            r_rsp_id     <= w_grant1;
            r_rsp_data   <= w_illegal ? '0 : alu_result;
            r_rsp_zero   <= w_illegal ? 1'b0 : alu_zero;
            r_rsp_err    <= w_illegal;
            r_last_grant <= w_grant1;
        end else if (rsp_ready) begin
            r_slot_state <= c_slot_empty;
        end
    end

    assign rsp_valid = (r_slot_state == c_slot_full);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter: directed vector table
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             alu_zero;
    logic             rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, anything else passes a.
    function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_ctrl, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic             rst, v0, v1;
        logic [3:0]       c0, c1;
        logic [WIDTH-1:0] a0, b0, a1, b1;
        logic             rr;
        logic             r0, r1;
        logic             ev, eid;
        logic [WIDTH-1:0] ed;
        logic             ez, ee;
    } vec_t;

    function automatic vec_t mk(input logic rs, v0, v1, input logic [3:0] c0, c1,
                                input logic [WIDTH-1:0] a0, b0, a1, b1, input logic rr,
                                input logic r0, r1, ev, eid, input logic [WIDTH-1:0] ed,
                                input logic ez, ee);
        vec_t v;
        v.rst = rs; v.v0 = v0; v.v1 = v1; v.c0 = c0; v.c1 = c1;
        v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1; v.rr = rr;
        v.r0 = r0; v.r1 = r1; v.ev = ev; v.eid = eid; v.ed = ed; v.ez = ez; v.ee = ee;
        return v;
    endfunction

    task automatic drive(input logic rs, v0, v1, input logic [3:0] c0, c1,
                         input logic [WIDTH-1:0] a0, b0, a1, b1, input logic rr);
        rst = rs; req0_valid = v0; req1_valid = v1; req0_ctrl = c0; req1_ctrl = c1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1; rsp_ready = rr;
    endtask

    vec_t vecs[21];

    // Reference model state: the response slot and who won the last contention.
    logic             m_valid, m_id, m_zero, m_err;
    logic [WIDTH-1:0] m_data;
    int               m_last;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0, 1'b0);

        //               rst v0 v1 c0 c1   a0 b0 a1 b1     rr   r0 r1 ev id data z  e
        vecs[0]  = mk(1, 1, 1, 0, 0, 1, 1, 1, 1, 1,        0, 0, 0, 0, 0,  0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0, 0,  0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 5, 7, 0, 0, 1,        1, 0, 1, 0, 12, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0, 12, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 4, 0, 0, 'hF0, 'h0F, 1,  0, 1, 1, 1, 'hFF, 0, 0);
        vecs[5]  = mk(0, 1, 1, 0, 1, 1, 2, 10, 4, 1,       1, 0, 1, 0, 3,  0, 0);
        vecs[6]  = mk(0, 1, 1, 0, 1, 1, 2, 10, 4, 1,       0, 1, 1, 1, 6,  0, 0);
        vecs[7]  = mk(0, 1, 1, 0, 1, 1, 2, 10, 4, 1,       1, 0, 1, 0, 3,  0, 0);
        vecs[8]  = mk(0, 1, 1, 0, 1, 1, 2, 10, 4, 1,       0, 1, 1, 1, 6,  0, 0);
        vecs[9]  = mk(0, 1, 1, 0, 1, 1, 2, 10, 4, 0,       0, 0, 1, 1, 6,  0, 0);
        vecs[10] = mk(0, 1, 1, 0, 1, 1, 2, 10, 4, 0,       0, 0, 1, 1, 6,  0, 0);
        vecs[11] = mk(0, 1, 1, 0, 1, 1, 2, 10, 4, 0,       0, 0, 1, 1, 6,  0, 0);
        vecs[12] = mk(0, 1, 1, 0, 1, 1, 2, 10, 4, 1,       1, 0, 1, 0, 3,  0, 0);
        vecs[13] = mk(0, 0, 1, 0, 15, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
                                                           0, 1, 1, 1, 0,  0, 1);
        vecs[14] = mk(0, 1, 0, 0, 0, 1, 2, 0, 0, 1,        1, 0, 1, 0, 3,  0, 0);
        vecs[15] = mk(0, 1, 0, 1, 0, 9, 9, 0, 0, 1,        1, 0, 1, 0, 0,  1, 0);
        vecs[16] = mk(0, 1, 0, 0, 0, 4, 4, 0, 0, 0,        0, 0, 1, 0, 0,  1, 0);
        vecs[17] = mk(1, 1, 1, 0, 0, 4, 4, 3, 3, 0,        0, 0, 0, 0, 0,  0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0,  0, 0);
        vecs[19] = mk(0, 1, 1, 0, 0, 2, 2, 3, 3, 1,        1, 0, 1, 0, 4,  0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 1, 0, 4,  0, 0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].v1, vecs[i].c0, vecs[i].c1,
                  vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1, vecs[i].rr);
            @(negedge clk);
            chk($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].r0));
            chk($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].r1));
            @(posedge clk); #1;
            chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d rsp_id", i),    32'(rsp_id),    32'(vecs[i].eid));
            chk($sformatf("vec%0d rsp_data", i),  rsp_data,       vecs[i].ed);
            chk($sformatf("vec%0d rsp_zero", i),  32'(rsp_zero),  32'(vecs[i].ez));
            chk($sformatf("vec%0d rsp_err", i),   32'(rsp_err),   32'(vecs[i].ee));
        end

        // Randomized traffic; the first cycle is a reset so the model starts in sync.
        m_valid = 0; m_id = 0; m_data = '0; m_zero = 0; m_err = 0; m_last = 1;
        for (int n = 0; n < 400; n++) begin
            logic             t_rst, t_v0, t_v1, t_rr;
            logic [3:0]       t_c0, t_c1, e_ctrl;
            logic [WIDTH-1:0] t_a0, t_b0, t_a1, t_b1, e_a, e_b, res;
            int               g;
            t_rst = (n == 0) || ($urandom_range(0, 39) == 0);
            t_v0  = 1'($urandom_range(0, 1));
            t_v1  = 1'($urandom_range(0, 1));
            t_rr  = ($urandom_range(0, 9) < 7);
            t_c0  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
            t_c1  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
            t_a0  = $urandom;
            t_b0  = ($urandom_range(0, 3) == 0) ? t_a0 : $urandom;
            t_a1  = $urandom;
            t_b1  = ($urandom_range(0, 3) == 0) ? t_a1 : $urandom;
            drive(t_rst, t_v0, t_v1, t_c0, t_c1, t_a0, t_b0, t_a1, t_b1, t_rr);

            g = -1;
            if (!t_rst && (!m_valid || t_rr)) begin
                if (t_v0 && t_v1) g = (m_last == 0) ? 1 : 0;
                else if (t_v0)    g = 0;
                else if (t_v1)    g = 1;
            end
            e_ctrl = (g == 0) ? t_c0 : (g == 1) ? t_c1 : 4'hF;
            e_a    = (g == 0) ? t_a0 : (g == 1) ? t_a1 : '0;
            e_b    = (g == 0) ? t_b0 : (g == 1) ? t_b1 : '0;

            @(negedge clk);
            chk("rnd req0_ready", 32'(req0_ready), 32'(g == 0));
            chk("rnd req1_ready", 32'(req1_ready), 32'(g == 1));
            chk("rnd alu_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
            chk("rnd alu_a", alu_a, e_a);
            chk("rnd alu_b", alu_b, e_b);

            @(posedge clk); #1;
            if (t_rst) begin
                m_valid = 0; m_id = 0; m_data = '0; m_zero = 0; m_err = 0; m_last = 1;
            end else if (g >= 0) begin
                res     = ref_alu(e_ctrl, e_a, e_b);
                m_valid = 1;
                m_id    = (g == 1);
                m_err   = (e_ctrl == 4'hF);
                m_data  = m_err ? '0 : res;
                m_zero  = m_err ? 1'b0 : (res == '0);
                m_last  = g;
            end else if (t_rr) begin
                m_valid = 0;
            end
            chk("rnd rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("rnd rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rnd rsp_data", rsp_data, m_data);
            chk("rnd rsp_zero", 32'(rsp_zero), 32'(m_zero));
            chk("rnd rsp_err", 32'(rsp_err), 32'(m_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
